// File: rtl/fetch_queue.sv
// Instruction-fetch front end: pipelined sequential PC requests, in-order responses buffered in a DEPTH-entry FIFO.
// Latency: response to if_valid_o is 1 cycle (0 when FETCH_BYPASS_EN is defined, the queue is empty and downstream is ready).
// Backpressure: requests stall on MAX_OUTSTANDING or on credits (outstanding + fifo + drop) reaching DEPTH; if_resp_ready_o is always 1.
module fetch_queue #(
    parameter int unsigned          PC_WIDTH        = 32,
    parameter int unsigned          INSTR_WIDTH     = 32,
    parameter int unsigned          DEPTH           = 4,
    parameter int unsigned          MAX_OUTSTANDING = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_PC        = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_i,
    input  logic [PC_WIDTH-1:0]     redirect_pc_i,
    output logic                    if_req_valid_o,
    input  logic                    if_req_ready_i,
    output logic [PC_WIDTH-1:0]     if_req_pc_o,
    input  logic                    if_resp_valid_i,
    output logic                    if_resp_ready_o,
    input  logic                    if_resp_err_i,
    input  logic [INSTR_WIDTH-1:0]  if_resp_instr_i,
    output logic                    if_valid_o,
    input  logic                    if_ready_i,
    output logic [PC_WIDTH-1:0]     if_pc_o,
    output logic [INSTR_WIDTH-1:0]  if_instr_o,
    output logic                    if_err_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0]   MAX_W   = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   err;
    } entry_t;

    state_t                 state_q, state_n;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_n;
    logic [CW-1:0]          out_q, out_n, drop_q, drop_n, fifo_cnt_q;
    logic [PW-1:0]          fifo_wr_q, fifo_rd_q, pcq_wr_q, pcq_rd_q;
    entry_t                 fifo_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pcq_mem  [DEPTH];

    logic [CW+1:0]  credits;
    logic           req_fire, resp_keep, bypass, push, pop, fifo_empty;
    entry_t         resp_entry, out_entry;

    assign credits    = {2'b00, out_q} + {2'b00, fifo_cnt_q} + {2'b00, drop_q};
    assign fifo_empty = (fifo_cnt_q == '0);

    assign if_req_valid_o  = !rst && (state_q == RUN) && !redirect_i
                             && ({1'b0, out_q} < MAX_W) && (credits < DEPTH_W);
    assign if_req_pc_o     = fetch_pc_q;
    assign if_resp_ready_o = 1'b1;
    assign req_fire        = if_req_valid_o && if_req_ready_i;

    // Stale responses (pending drop or same-cycle redirect) still consume their PC queue slot.
    assign resp_keep        = if_resp_valid_i && !redirect_i && (drop_q == '0);
    assign resp_entry.pc    = pcq_mem[pcq_rd_q];
    assign resp_entry.instr = if_resp_err_i ? '0 : if_resp_instr_i;
    assign resp_entry.err   = if_resp_err_i;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && fifo_empty && if_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push      = resp_keep && !bypass;
    assign pop       = !rst && !redirect_i && !fifo_empty && if_ready_i;
    assign out_entry = bypass ? resp_entry : fifo_mem[fifo_rd_q];

    assign if_valid_o = !rst && !redirect_i && (!fifo_empty || bypass);
    assign if_pc_o    = out_entry.pc;
    assign if_instr_o = out_entry.instr;
    assign if_err_o   = out_entry.err;

    always_comb begin
        logic [CW:0] out_w, drop_w, sum_w;
        logic        dec_drop;
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        out_n      = out_q;
        drop_n     = drop_q;
        dec_drop   = if_resp_valid_i && (drop_q != '0);
        out_w      = {1'b0, out_q} + (CW+1)'(req_fire) - (CW+1)'(if_resp_valid_i && !dec_drop);
        drop_w     = {1'b0, drop_q} - (CW+1)'(dec_drop);
        sum_w      = {1'b0, drop_q} + {1'b0, out_q} + (CW+1)'(req_fire) - (CW+1)'(if_resp_valid_i);
        if (redirect_i) begin
            // Everything still in flight becomes stale; last redirect wins.
            state_n    = RUN;
            fetch_pc_n = redirect_pc_i;
            out_n      = '0;
            drop_n     = (sum_w > MAX_W) ? MAX_W[CW-1:0] : sum_w[CW-1:0];
        end else begin
            if (req_fire)
                fetch_pc_n = fetch_pc_q + PC_WIDTH'(4);
            if (resp_keep && if_resp_err_i) begin
                state_n = HALT;
                sum_w   = drop_w + out_w;
                out_n   = '0;
                drop_n  = (sum_w > MAX_W) ? MAX_W[CW-1:0] : sum_w[CW-1:0];
            end else begin
                out_n  = out_w[CW-1:0];
                drop_n = drop_w[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            out_q      <= out_n;
            drop_q     <= drop_n;
            if (req_fire)
                pcq_wr_q <= pcq_wr_q + 1'b1;
            if (if_resp_valid_i)
                pcq_rd_q <= pcq_rd_q + 1'b1;
            if (redirect_i) begin
                fifo_cnt_q <= '0;
                fifo_wr_q  <= '0;
                fifo_rd_q  <= '0;
            end else begin
                if (push)
                    fifo_wr_q <= fifo_wr_q + 1'b1;
                if (pop)
                    fifo_rd_q <= fifo_rd_q + 1'b1;
                fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcq_mem[pcq_wr_q] <= fetch_pc_q;
        if (push)
            fifo_mem[fifo_wr_q] <= resp_entry;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (base build): one row per clock cycle of inputs and expected outputs.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_req_valid_o;
    logic        if_req_ready_i;
    logic [31:0] if_req_pc_o;
    logic        if_resp_valid_i;
    logic        if_resp_ready_o;
    logic        if_resp_err_i;
    logic [31:0] if_resp_instr_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .if_req_valid_o  (if_req_valid_o),
        .if_req_ready_i  (if_req_ready_i),
        .if_req_pc_o     (if_req_pc_o),
        .if_resp_valid_i (if_resp_valid_i),
        .if_resp_ready_o (if_resp_ready_o),
        .if_resp_err_i   (if_resp_err_i),
        .if_resp_instr_i (if_resp_instr_i),
        .if_valid_o      (if_valid_o),
        .if_ready_i      (if_ready_i),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o),
        .if_err_o        (if_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        req_rdy;
        logic        rsp_vld;
        logic        rsp_err;
        logic [31:0] rsp_instr;
        logic        if_rdy;
        logic        e_req_vld;
        logic [31:0] e_req_pc;
        logic        e_if_vld;
        logic [31:0] e_if_pc;
        logic [31:0] e_if_instr;
        logic        e_if_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic redir, input logic [31:0] rpc, input logic req_rdy,
                       input logic rsp_vld, input logic rsp_err, input logic [31:0] rsp_instr,
                       input logic if_rdy, input logic e_req_vld, input logic [31:0] e_req_pc,
                       input logic e_if_vld, input logic [31:0] e_if_pc,
                       input logic [31:0] e_if_instr, input logic e_if_err);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.req_rdy = req_rdy; v.rsp_vld = rsp_vld;
        v.rsp_err = rsp_err; v.rsp_instr = rsp_instr; v.if_rdy = if_rdy;
        v.e_req_vld = e_req_vld; v.e_req_pc = e_req_pc; v.e_if_vld = e_if_vld;
        v.e_if_pc = e_if_pc; v.e_if_instr = e_if_instr; v.e_if_err = e_if_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic redir, input logic [31:0] rpc,
                         input logic req_rdy, input logic rsp_vld, input logic rsp_err,
                         input logic [31:0] rsp_instr, input logic if_rdy);
        rst = r; redirect_i = redir; redirect_pc_i = rpc; if_req_ready_i = req_rdy;
        if_resp_valid_i = rsp_vld; if_resp_err_i = rsp_err; if_resp_instr_i = rsp_instr;
        if_ready_i = if_rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [31:0] B = 32'h8000_0000;
        // Basic streaming: response one cycle after accept, downstream always ready.
        add(0, 0, 1, 0, 0, 0,            1, 1, B,       0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'h11111111, 1, 1, B+4,     0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'h22222222, 1, 1, B+8,     1, B,       32'h11111111, 0);
        add(0, 0, 1, 1, 0, 32'h33333333, 1, 1, B+12,    1, B+4,     32'h22222222, 0);
        add(0, 0, 0, 1, 0, 32'h44444444, 1, 1, B+16,    1, B+8,     32'h33333333, 0);
        add(0, 0, 0, 0, 0, 0,            1, 1, B+16,    1, B+12,    32'h44444444, 0);
        // Downstream stalled: fill to 4 entries, requests stop on credits.
        add(0, 0, 1, 0, 0, 0,            0, 1, B+16,    0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'hA0000000, 0, 1, B+20,    0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'hA0000001, 0, 1, B+24,    1, B+16,    32'hA0000000, 0);
        add(0, 0, 1, 1, 0, 32'hA0000002, 0, 1, B+28,    1, B+16,    32'hA0000000, 0);
        add(0, 0, 1, 1, 0, 32'hA0000003, 0, 0, 0,       1, B+16,    32'hA0000000, 0);
        add(0, 0, 1, 0, 0, 0,            0, 0, 0,       1, B+16,    32'hA0000000, 0);
        // Drain 4 in order; held request PC stays stable while not accepted.
        add(0, 0, 0, 0, 0, 0,            1, 0, 0,       1, B+16,    32'hA0000000, 0);
        add(0, 0, 0, 0, 0, 0,            1, 1, B+32,    1, B+20,    32'hA0000001, 0);
        add(0, 0, 0, 0, 0, 0,            1, 1, B+32,    1, B+24,    32'hA0000002, 0);
        add(0, 0, 0, 0, 0, 0,            1, 1, B+32,    1, B+28,    32'hA0000003, 0);
        // Two accepts without responses hit MAX_OUTSTANDING.
        add(0, 0, 1, 0, 0, 0,            1, 1, B+32,    0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            1, 1, B+36,    0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            1, 0, 0,       0, 0,       0,            0);
        // Redirect with two in flight: both stale responses dropped.
        add(1, 32'h100, 1, 0, 0, 0,      1, 0, 0,       0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'hDEAD0000, 1, 1, 32'h100, 0, 0,       0,            0);
        add(0, 0, 0, 1, 0, 32'hDEAD0004, 1, 1, 32'h104, 0, 0,       0,            0);
        add(0, 0, 0, 1, 0, 32'hA0A0A0A0, 1, 1, 32'h104, 0, 0,       0,            0);
        add(0, 0, 0, 0, 0, 0,            1, 1, 32'h104, 1, 32'h100, 32'hA0A0A0A0, 0);
        // Bus error on B+4: delivered with zero instr, then HALT drops the in-flight B+8.
        add(1, B, 0, 0, 0, 0,            0, 0, 0,       0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            0, 1, B,       0, 0,       0,            0);
        add(0, 0, 1, 1, 0, 32'h13,       0, 1, B+4,     0, 0,       0,            0);
        add(0, 0, 1, 1, 1, 32'hBADBAD00, 0, 1, B+8,     1, B,       32'h13,       0);
        add(0, 0, 1, 1, 0, 32'h77,       1, 0, 0,       1, B,       32'h13,       0);
        add(0, 0, 1, 0, 0, 0,            1, 0, 0,       1, B+4,     0,            1);
        add(0, 0, 1, 0, 0, 0,            1, 0, 0,       0, 0,       0,            0);
        add(1, 32'h200, 1, 0, 0, 0,      1, 0, 0,       0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            1, 1, 32'h200, 0, 0,       0,            0);
        // Redirect colliding with a response and a would-be pop.
        add(0, 0, 0, 1, 0, 32'h20000000, 0, 1, 32'h204, 0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            0, 1, 32'h204, 1, 32'h200, 32'h20000000, 0);
        add(1, 32'h300, 1, 1, 0, 32'h55, 1, 0, 0,       0, 0,       0,            0);
        add(0, 0, 0, 0, 0, 0,            1, 1, 32'h300, 0, 0,       0,            0);
        // PC wrap at the top of the address space.
        add(1, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0,       0, 0,       0,            0);
        add(0, 0, 1, 0, 0, 0,            1, 1, 32'hFFFFFFFC, 0, 0,  0,            0);
        add(0, 0, 0, 1, 0, 32'h99,       1, 1, 32'h0,   0, 0,       0,            0);
        add(0, 0, 0, 0, 0, 0,            1, 1, 32'h0,   1, 32'hFFFFFFFC, 32'h99,  0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_vld",  32'(if_req_valid_o),  32'd0);
        chk("reset_if_vld",   32'(if_valid_o),      32'd0);
        chk("reset_resp_rdy", 32'(if_resp_ready_o), 32'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(0, vecs[i].redir, vecs[i].rpc, vecs[i].req_rdy, vecs[i].rsp_vld,
                  vecs[i].rsp_err, vecs[i].rsp_instr, vecs[i].if_rdy);
            #1;
            chk($sformatf("row%0d_req_vld", i),  32'(if_req_valid_o),  32'(vecs[i].e_req_vld));
            chk($sformatf("row%0d_resp_rdy", i), 32'(if_resp_ready_o), 32'd1);
            chk($sformatf("row%0d_if_vld", i),   32'(if_valid_o),      32'(vecs[i].e_if_vld));
            if (vecs[i].e_req_vld)
                chk($sformatf("row%0d_req_pc", i), if_req_pc_o, vecs[i].e_req_pc);
            if (vecs[i].e_if_vld) begin
                chk($sformatf("row%0d_if_pc", i),    if_pc_o,          vecs[i].e_if_pc);
                chk($sformatf("row%0d_if_instr", i), if_instr_o,       vecs[i].e_if_instr);
                chk($sformatf("row%0d_if_err", i),   32'(if_err_o),    32'(vecs[i].e_if_err));
            end
        end

        // Reset asserted mid-operation with a request in flight and an entry buffered.
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("mid_req_pc0", if_req_pc_o, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 0, 32'hCC, 0);
        #1;
        chk("mid_req_pc4", if_req_pc_o, 32'h4);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_req_vld",  32'(if_req_valid_o),  32'd0);
        chk("mid_rst_if_vld",   32'(if_valid_o),      32'd0);
        chk("mid_rst_resp_rdy", 32'(if_resp_ready_o), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_req_vld", 32'(if_req_valid_o), 32'd1);
        chk("post_rst_req_pc",  if_req_pc_o,         32'h8000_0000);
        chk("post_rst_if_vld",  32'(if_valid_o),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end; successor to the single-slot fetch stage.
- Generates sequential PCs and issues pipelined requests on the if_req/if_resp memory bus, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to the IF/ID register through a valid/ready handshake.
- Handles redirects (branch/trap), discarding stale in-flight responses, and stops fetching after a bus error.

Parameters:
- PC_WIDTH, 32, fetch address width.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..DEPTH).
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  PC_WIDTH  restart target.
- if_req_valid_o  out  1  request valid.
- if_req_ready_i  in  1  bus accepts request.
- if_req_pc_o  out  PC_WIDTH  request address.
- if_resp_valid_i  in  1  response valid.
- if_resp_ready_o  out  1  response accepted.
- if_resp_err_i  in  1  response carries bus error.
- if_resp_instr_i  in  INSTR_WIDTH  fetched instruction.
- if_valid_o  out  1  head entry valid toward IF/ID.
- if_ready_i  in  1  IF/ID consumes head.
- if_pc_o  out  PC_WIDTH  head PC.
- if_instr_o  out  INSTR_WIDTH  head instruction (0 when if_err_o is set).
- if_err_o  out  1  head is a fetch fault.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and rst.
- Reset values:
  - fetch PC = RESET_PC;
  - FIFO empty;
  - outstanding count = 0, drop count = 0;
  - state = RUN;
  - all valid outputs 0; if_resp_ready_o = 1.
- Reset asserted mid-operation discards everything. Responses arriving after reset to pre-reset requests are not guarded; the bus must be reset together with this block.
- States:
  - RUN: fetching.
  - HALT: entered when an error response is enqueued. Stops requests; exits only on redirect_i.
- Credits: outstanding + fifo_count + drop_count counts against DEPTH.
- Request issue: if_req_valid_o = (state==RUN) & !redirect_i & outstanding<MAX_OUTSTANDING & credits<DEPTH.
  - if_req_pc_o = fetch PC.
  - Valid and PC are held stable until accepted; they may be withdrawn only on redirect_i.
- On accept (valid & ready): fetch PC += 4 (wraps modulo 2^PC_WIDTH); outstanding += 1.
- Responses:
  - Always accepted; if_resp_ready_o = 1 at all times, and the credit rule guarantees space.
  - Responses return in request order. Each response decrements drop_count if drop_count>0 (response discarded), else decrements outstanding.
  - A non-discarded response is written to the FIFO as {pc, instr, err}. The entry PC comes from an internal PC queue of in-flight addresses.
- Output: the head entry is presented on if_*_o; it is popped on if_valid_o & if_ready_i.
  - Latency: response in cycle M appears on if_valid_o in cycle M+1 (base build).
- Simultaneous push and pop in the same cycle are both performed, so the count is unchanged. Full and empty never both block, because of the credit rule.
- Error: an entry with err=1 is delivered normally; the state goes to HALT in the cycle it is enqueued. Later responses to requests already in flight are discarded (they move to drop_count).
- Redirect (cycle N) has priority over every other event in cycle N:
  - FIFO cleared, and if_valid_o forced 0 in cycle N, so no pop occurs;
  - drop_count += outstanding, including a request accepted in cycle N;
  - a response in cycle N is discarded;
  - fetch PC = redirect_pc_i; state = RUN;
  - the first request for the target is presented in cycle N+1.
- Back-to-back redirects: the last one wins. drop_count saturates at MAX_OUTSTANDING.
- Counter widths are $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- When defined: if the FIFO is empty, no entries are pending, the response is not discarded, redirect_i=0 and if_ready_i=1, the response is driven combinationally onto if_*_o in the same cycle (latency 0) and is not written to the FIFO.
  - If if_ready_i=0, the response is enqueued normally.
- When undefined: the response always passes through the FIFO, giving minimum latency 1.

Test Plan:
- Reset then if_req_ready_i=1, response 1 cycle after accept, if_ready_i=1 -> requests at PCs 0x80000000, 0x80000004, 0x80000008 in order; if_pc_o/if_instr_o match; at most 2 outstanding.
- if_ready_i=0 with continuous responses -> exactly 4 entries buffered and if_req_valid_o=0. Raise if_ready_i -> 4 pops in order, then fetching resumes.
- 2 requests outstanding, redirect_pc_i=0x100 -> both stale responses discarded; next request at 0x100 one cycle after the redirect; first output PC 0x100.
- Error response on PC 0x80000004 -> delivered with if_err_o=1, if_instr_o=0; no further requests. Redirect to 0x200 -> fetch resumes at 0x200.
- Redirect in the same cycle as a response and a downstream pop -> the response is discarded, the FIFO is empty next cycle, and no pop handshake is counted.
- Fetch PC 0xFFFFFFFC -> next request at 0x00000000 (wrap). With FETCH_BYPASS_EN, on an empty queue the response appears on if_valid_o in the same cycle.
